// File: rtl/drive_pkg.sv
// Shared types and constants for the line-following drive controller.
// Holds the state set, motor direction encoding and default timing.
package drive_pkg;

  localparam int DEF_PERIOD       = 2_000_000;
  localparam int DEF_STOP_PERIODS = 3;

  localparam logic CW  = 1'b1;
  localparam logic CCW = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_SOFT_L,
    S_HARD_L,
    S_SOFT_R,
    S_HARD_R,
    S_STOP
  } state_t;

  typedef struct packed {
    logic mrst_l;
    logic dir_l;
    logic mrst_r;
    logic dir_r;
  } motor_t;

  localparam motor_t MOTORS_OFF = '{
    mrst_l: 1'b1, dir_l: CCW,
    mrst_r: 1'b1, dir_r: CCW
  };

  // Right motor is mirrored, so CCW drives it forward.
  function automatic motor_t decode(
    input state_t s
  );
    motor_t m;
    m = MOTORS_OFF;
    case (s)
      S_FWD:    m = '{1'b0, CW,  1'b0, CCW};
      S_SOFT_L: m = '{1'b1, CCW, 1'b0, CCW};
      S_HARD_L: m = '{1'b0, CCW, 1'b0, CCW};
      S_SOFT_R: m = '{1'b0, CW,  1'b1, CCW};
      S_HARD_R: m = '{1'b0, CW,  1'b0, CW};
      default:  m = MOTORS_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/drive_controller_timebase.sv
// Free-running PWM frame counter with a one-cycle tick
// on the last count of each frame.
module timebase
  import drive_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [20:0] count,
  output logic        tick
);

  localparam int TW =
    (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

  logic [TW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign count = 21'(r_cnt);
  assign tick  = w_tick;

endmodule

// File: rtl/drive_controller.sv
// Line-following drive controller: picks a steering state once per
// PWM frame from synchronized sensors and drives both motor controls.
module drive_controller
  import drive_pkg::*;
#(
  parameter int PERIOD       = DEF_PERIOD,
  parameter int STOP_PERIODS = DEF_STOP_PERIODS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  sensor,
  output logic [20:0] count_out,
  output logic        dir_l,
  output logic        dir_r,
  output logic        mrst_l,
  output logic        mrst_r
);

  localparam int SCW = $clog2(STOP_PERIODS + 1);
  localparam logic [SCW-1:0] STOP_MAX =
    SCW'(STOP_PERIODS);

  logic           r_en_s1;
  logic           r_en_s2;
  logic [2:0]     r_sen_s1;
  logic [2:0]     r_sen_s2;
  state_t         r_state;
  state_t         w_nxt;
  logic [SCW-1:0] r_scnt;
  logic [SCW-1:0] w_scnt_nxt;
  motor_t         r_out;
  logic           w_tick;

  timebase #(
    .PERIOD (PERIOD)
  ) u_tb (
    .clk   (clk),
    .rst_n (reset),
    .count (count_out),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_s1  <= 1'b0;
      r_en_s2  <= 1'b0;
      r_sen_s1 <= '0;
      r_sen_s2 <= '0;
    end else begin
      r_en_s1  <= enable;
      r_en_s2  <= r_en_s1;
      r_sen_s1 <= sensor;
      r_sen_s2 <= r_sen_s1;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_scnt_nxt = r_scnt;
    if (!r_en_s2) begin
      w_nxt      = S_IDLE;
      w_scnt_nxt = '0;
    end else if (w_tick && r_state != S_STOP) begin
      w_scnt_nxt = '0;
      case (r_sen_s2)
        3'b010,
        3'b101: w_nxt = S_FWD;
        3'b110: w_nxt = S_SOFT_L;
        3'b100: w_nxt = S_HARD_L;
        3'b011: w_nxt = S_SOFT_R;
        3'b001: w_nxt = S_HARD_R;
        3'b111: begin
          // Saturate so a long stop marker cannot wrap.
          w_scnt_nxt = (r_scnt == STOP_MAX) ?
            r_scnt : r_scnt + 1'b1;
          if (w_scnt_nxt == STOP_MAX) begin
            w_nxt = S_STOP;
          end
        end
        default: w_nxt = r_state;
      endcase
    end
  end

  // Outputs come from the next state so they move on the state edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_out   <= MOTORS_OFF;
    end else begin
      r_state <= w_nxt;
      r_scnt  <= w_scnt_nxt;
      r_out   <= decode(w_nxt);
    end
  end

  assign mrst_l = r_out.mrst_l;
  assign dir_l  = r_out.dir_l;
  assign mrst_r = r_out.mrst_r;
  assign dir_r  = r_out.dir_r;

endmodule

// File: tb/tb_drive_controller.sv
// Self-checking bench for drive_controller: table of frames,
// hand corner sequences and a randomized run against a frame model.
module tb_drive_controller;

  localparam int P  = 20;
  localparam int SP = 3;

  localparam int M_IDLE   = 0;
  localparam int M_FWD    = 1;
  localparam int M_SOFT_L = 2;
  localparam int M_HARD_L = 3;
  localparam int M_SOFT_R = 4;
  localparam int M_HARD_R = 5;
  localparam int M_STOP   = 6;
  localparam int M_HOLD   = -1;
  localparam int M_MARK   = -2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  sensor;
  logic [20:0] count_out;
  logic        dir_l;
  logic        dir_r;
  logic        mrst_l;
  logic        mrst_r;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] prev_exp;

  // {mrst_l, dir_l, mrst_r, dir_r} per model state
  logic [3:0] m_out [7];
  // steering target per sensor pattern
  int         m_dest [8];
  int         m_state;
  int         m_cnt;

  typedef struct {
    logic       en;
    logic [2:0] sen;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  drive_controller #(
    .PERIOD       (P),
    .STOP_PERIODS (SP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sensor    (sensor),
    .count_out (count_out),
    .dir_l     (dir_l),
    .dir_r     (dir_r),
    .mrst_l    (mrst_l),
    .mrst_r    (mrst_r)
  );

  function automatic logic [3:0] outs();
    return {mrst_l, dir_l, mrst_r, dir_r};
  endfunction

  task automatic check4(
    input string      name,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b",
               name, got, exp);
    end
  endtask

  task automatic checkn(
    input string name,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d",
               name, got, exp);
    end
  endtask

  task automatic wait_count(input int v);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3 * P; k++) begin
      @(negedge clk);
      if (int'(count_out) == v) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_count: got timeout required %0d",
               v);
    end
  endtask

  task automatic edges_to_wrap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (count_out != 0 && n < 3 * P);
  endtask

  task automatic run_frame(
    input logic       en,
    input logic [2:0] sen,
    input logic [3:0] exp,
    input string      name
  );
    wait_count(2);
    enable = en;
    sensor = sen;
    wait_count(10);
    check4({name, "_mid"}, outs(),
           en ? prev_exp : 4'b1010);
    wait_count(0);
    check4(name, outs(), exp);
    prev_exp = exp;
  endtask

  task automatic model_step(
    input logic       en,
    input logic [2:0] s
  );
    if (!en) begin
      m_state = M_IDLE;
      m_cnt   = 0;
    end else if (m_state != M_STOP) begin
      if (m_dest[s] == M_MARK) begin
        m_cnt = (m_cnt < SP) ? m_cnt + 1 : SP;
        if (m_cnt == SP) m_state = M_STOP;
      end else begin
        m_cnt = 0;
        if (m_dest[s] != M_HOLD) m_state = m_dest[s];
      end
    end
  endtask

  initial begin
    int         n;
    logic       en;
    logic [2:0] s;

    m_out = '{4'b1010, 4'b0100, 4'b1000, 4'b0000,
              4'b0110, 4'b0101, 4'b1010};
    m_dest = '{M_HOLD, M_HARD_R, M_FWD, M_SOFT_R,
               M_HARD_L, M_FWD, M_SOFT_L, M_MARK};

    vecs = '{
      '{1'b1, 3'b100, 4'b0000},
      '{1'b1, 3'b110, 4'b1000},
      '{1'b1, 3'b011, 4'b0110},
      '{1'b1, 3'b001, 4'b0101},
      '{1'b1, 3'b000, 4'b0101},
      '{1'b1, 3'b101, 4'b0100},
      '{1'b1, 3'b111, 4'b0100},
      '{1'b1, 3'b111, 4'b0100},
      '{1'b1, 3'b010, 4'b0100},
      '{1'b1, 3'b111, 4'b0100},
      '{1'b1, 3'b111, 4'b0100},
      '{1'b1, 3'b111, 4'b1010},
      '{1'b1, 3'b010, 4'b1010},
      '{1'b0, 3'b010, 4'b1010},
      '{1'b1, 3'b000, 4'b1010},
      '{1'b1, 3'b000, 4'b1010},
      '{1'b1, 3'b110, 4'b1000}
    };

    reset  = 1'b0;
    enable = 1'b1;
    sensor = 3'b010;
    repeat (3) @(negedge clk);
    checkn("reset_count", int'(count_out), 0);
    check4("reset_outs", outs(), 4'b1010);

    reset = 1'b1;
    edges_to_wrap(n);
    checkn("first_wrap", n, P);
    check4("first_fwd", outs(), 4'b0100);
    for (int i = 0; i < P - 1; i++) begin
      @(negedge clk);
      check4("fwd_steady", outs(), 4'b0100);
    end
    prev_exp = 4'b0100;

    foreach (vecs[i]) begin
      run_frame(vecs[i].en, vecs[i].sen, vecs[i].exp,
                $sformatf("vec%0d", i));
    end

    wait_count(5);
    sensor = 3'b100;
    wait_count(10);
    check4("midframe_hold10", outs(), 4'b1000);
    wait_count(18);
    check4("midframe_hold18", outs(), 4'b1000);
    wait_count(0);
    check4("midframe_wrap", outs(), 4'b0000);

    wait_count(5);
    sensor = 3'b011;
    @(negedge clk);
    sensor = 3'b100;
    wait_count(0);
    check4("pulse_ignored", outs(), 4'b0000);

    wait_count(7);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check4("en_drop", outs(), 4'b1010);
    sensor = 3'b000;
    enable = 1'b1;
    wait_count(0);
    check4("idle_000_a", outs(), 4'b1010);
    wait_count(0);
    check4("idle_000_b", outs(), 4'b1010);
    prev_exp = 4'b1010;
    run_frame(1'b1, 3'b011, 4'b0110, "to_soft_r");

    wait_count(11);
    #2;
    reset = 1'b0;
    #1;
    checkn("async_rst_count", int'(count_out), 0);
    check4("async_rst_outs", outs(), 4'b1010);
    @(negedge clk);
    reset = 1'b1;
    edges_to_wrap(n);
    checkn("rst_next_wrap", n, P);
    check4("rst_soft_r", outs(), 4'b0110);

    m_state = M_SOFT_R;
    m_cnt   = 0;
    for (int f = 0; f < 40; f++) begin
      en = ($urandom_range(0, 7) != 0);
      if (m_state == M_STOP && $urandom_range(0, 1) == 0)
        en = 1'b0;
      s = ($urandom_range(0, 2) == 0) ?
        3'b111 : 3'($urandom_range(0, 7));
      wait_count(2);
      enable = en;
      sensor = s;
      wait_count(8);
      sensor = 3'($urandom_range(0, 7));
      @(negedge clk);
      sensor = s;
      wait_count(12);
      check4($sformatf("rnd%0d_mid", f), outs(),
             en ? m_out[m_state] : m_out[M_IDLE]);
      model_step(en, s);
      wait_count(0);
      check4($sformatf("rnd%0d", f), outs(),
             m_out[m_state]);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
